// File: rtl/fifo_buffer_sync.sv
// Single-clock FIFO with wrap-around pointers, occupancy flags, sticky over/underflow and sync flush.
// Latency: show-ahead head word (mode 0) or 1-cycle registered pop (mode 1); pushes to a full FIFO are rejected unless a pop frees the slot.
module fifo_buffer_sync #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 8,
    parameter int ALMOST_FULL     = DEPTH - 1,
    parameter int ALMOST_EMPTY    = 1,
    parameter int READ_REGISTERED = 0
) (
    input  logic                         write_clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         write_enable,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic                         read_enable,
    output logic [DATA_WIDTH-1:0]        read_data,
    output logic                         read_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic read_ok;
    logic write_ok;
    logic push;
    logic pop;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (int'(count_q) >= ALMOST_FULL);
    assign almost_empty = (int'(count_q) <= ALMOST_EMPTY);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign read_ok  = read_enable && !empty;
    assign write_ok = write_enable && (!full || read_ok);
    assign push     = write_ok && !clear;
    assign pop      = read_ok && !clear;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (write_enable && !write_ok);
            underflow_d = underflow_q | (read_enable && !read_ok);
        end
    end

    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    generate
        if (READ_REGISTERED != 0) begin : g_read_reg
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;

            always_ff @(posedge write_clk or negedge reset) begin
                if (!reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= pop;
                    if (pop) begin
                        rdata_q <= mem_q[rd_ptr_q];
                    end
                end
            end

            assign read_data  = rdata_q;
            assign read_valid = rvalid_q;
        end else begin : g_read_ahead
            // Head word comes from storage only, so write_data never reaches read_data in the same cycle.
            assign read_data  = mem_q[rd_ptr_q];
            assign read_valid = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_buffer_sync.sv
// Scoreboarded bench for fifo_buffer_sync: three instances (depth 8 show-ahead, depth 5 wrap, depth 8 registered read).
module tb_fifo_buffer_sync;

    logic write_clk = 1'b0;
    logic reset     = 1'b1;
    always #5 write_clk = ~write_clk;

    logic       a_clr, a_we, a_re, a_rv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
    logic [7:0] a_wd, a_rd;
    logic [3:0] a_cnt;
    logic       b_clr, b_we, b_re, b_rv, b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [7:0] b_wd, b_rd;
    logic [2:0] b_cnt;
    logic       c_clr, c_we, c_re, c_rv, c_full, c_empty, c_af, c_ae, c_ov, c_un;
    logic [7:0] c_wd, c_rd;
    logic [3:0] c_cnt;

    fifo_buffer_sync #(.DATA_WIDTH(8), .DEPTH(8), .ALMOST_FULL(6), .ALMOST_EMPTY(2), .READ_REGISTERED(0)) u_a (
        .write_clk(write_clk), .reset(reset), .clear(a_clr), .write_enable(a_we), .write_data(a_wd),
        .read_enable(a_re), .read_data(a_rd), .read_valid(a_rv), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt), .overflow(a_ov), .underflow(a_un));

    fifo_buffer_sync #(.DATA_WIDTH(8), .DEPTH(5)) u_b (
        .write_clk(write_clk), .reset(reset), .clear(b_clr), .write_enable(b_we), .write_data(b_wd),
        .read_enable(b_re), .read_data(b_rd), .read_valid(b_rv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt), .overflow(b_ov), .underflow(b_un));

    fifo_buffer_sync #(.DATA_WIDTH(8), .DEPTH(8), .READ_REGISTERED(1)) u_c (
        .write_clk(write_clk), .reset(reset), .clear(c_clr), .write_enable(c_we), .write_data(c_wd),
        .read_enable(c_re), .read_data(c_rd), .read_valid(c_rv), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt), .overflow(c_ov), .underflow(c_un));

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] exp_c[$];
    logic [7:0] a_e, b_e, c_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge write_clk);
        #1;
    endtask

    // Monitors: show-ahead instances consume on an accepted pop, registered instance on read_valid.
    always @(negedge write_clk) begin
        if (reset && !a_clr && a_re && a_rv) begin
            if (exp_a.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL a_data: got %0h expected no pop", a_rd);
            end else begin
                a_e = exp_a.pop_front();
                chk("a_data", 32'(a_rd), 32'(a_e));
            end
        end
        if (reset && !b_clr && b_re && b_rv) begin
            if (exp_b.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL b_data: got %0h expected no pop", b_rd);
            end else begin
                b_e = exp_b.pop_front();
                chk("b_data", 32'(b_rd), 32'(b_e));
            end
        end
        if (reset && c_rv) begin
            if (exp_c.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL c_data: got %0h expected no valid", c_rd);
            end else begin
                c_e = exp_c.pop_front();
                chk("c_data", 32'(c_rd), 32'(c_e));
            end
        end
    end

    initial begin
        {a_clr, a_we, a_re, a_wd} = '0;
        {b_clr, b_we, b_re, b_wd} = '0;
        {c_clr, c_we, c_re, c_wd} = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_a_empty", 32'(a_empty), 1);
        chk("rst_a_full", 32'(a_full), 0);
        chk("rst_a_af", 32'(a_af), 0);
        chk("rst_a_ae", 32'(a_ae), 1);
        chk("rst_a_ov", 32'(a_ov), 0);
        chk("rst_a_un", 32'(a_un), 0);
        chk("rst_a_rv", 32'(a_rv), 0);
        chk("rst_a_rd", 32'(a_rd), 0);
        chk("rst_c_rv", 32'(c_rv), 0);
        chk("rst_c_rd", 32'(c_rd), 0);
        #9 reset = 1'b1;
        cyc();

        // Fill depth 8, overflow on 9th, drain in order.
        for (int i = 1; i <= 8; i++) begin
            a_we = 1'b1; a_wd = 8'(i); exp_a.push_back(8'(i));
            cyc();
        end
        a_we = 1'b0;
        chk("fill_cnt", 32'(a_cnt), 8);
        chk("fill_full", 32'(a_full), 1);
        chk("fill_af", 32'(a_af), 1);
        chk("fill_ae", 32'(a_ae), 0);
        a_we = 1'b1; a_wd = 8'h09;
        cyc();
        a_we = 1'b0;
        chk("ovf_flag", 32'(a_ov), 1);
        chk("ovf_cnt", 32'(a_cnt), 8);
        a_re = 1'b1;
        repeat (8) cyc();
        a_re = 1'b0;
        chk("drain_empty", 32'(a_empty), 1);
        chk("drain_cnt", 32'(a_cnt), 0);
        chk("ovf_sticky", 32'(a_ov), 1);
        chk("drain_un", 32'(a_un), 0);
        a_clr = 1'b1;
        cyc();
        a_clr = 1'b0;
        chk("clr_ov", 32'(a_ov), 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            a_we = 1'b1; a_wd = 8'(8'h10 + i); exp_a.push_back(8'(8'h10 + i));
            cyc();
        end
        a_we = 1'b1; a_re = 1'b1; a_wd = 8'h18; exp_a.push_back(8'h18);
        cyc();
        a_we = 1'b0; a_re = 1'b0;
        chk("fullrw_cnt", 32'(a_cnt), 8);
        chk("fullrw_full", 32'(a_full), 1);
        chk("fullrw_ov", 32'(a_ov), 0);
        a_re = 1'b1;
        repeat (8) cyc();
        a_re = 1'b0;
        chk("fullrw_empty", 32'(a_empty), 1);

        // Empty with simultaneous push and pop.
        a_we = 1'b1; a_re = 1'b1; a_wd = 8'h20; exp_a.push_back(8'h20);
        cyc();
        a_we = 1'b0; a_re = 1'b0;
        chk("emptyrw_un", 32'(a_un), 1);
        chk("emptyrw_cnt", 32'(a_cnt), 1);
        chk("emptyrw_rd", 32'(a_rd), 32'h20);
        a_re = 1'b1;
        cyc();
        a_re = 1'b0;
        chk("un_sticky", 32'(a_un), 1);
        a_clr = 1'b1;
        cyc();
        a_clr = 1'b0;
        chk("clr_un", 32'(a_un), 0);

        // Almost thresholds 6 and 2, count 0..8..0.
        chk("alm_cnt0", 32'(a_cnt), 0);
        chk("alm_ae0", 32'(a_ae), 1);
        for (int k = 1; k <= 8; k++) begin
            a_we = 1'b1; a_wd = 8'(8'h30 + k); exp_a.push_back(8'(8'h30 + k));
            cyc();
            a_we = 1'b0;
            chk("alm_up_cnt", 32'(a_cnt), 32'(k));
            chk("alm_up_af", 32'(a_af), (k >= 6) ? 1 : 0);
            chk("alm_up_ae", 32'(a_ae), (k <= 2) ? 1 : 0);
        end
        for (int k = 7; k >= 0; k--) begin
            a_re = 1'b1;
            cyc();
            a_re = 1'b0;
            chk("alm_dn_cnt", 32'(a_cnt), 32'(k));
            chk("alm_dn_af", 32'(a_af), (k >= 6) ? 1 : 0);
            chk("alm_dn_ae", 32'(a_ae), (k <= 2) ? 1 : 0);
        end

        // Depth 5: 13 words across several pointer wraps, count held at 2.
        b_we = 1'b1; b_wd = 8'h40; exp_b.push_back(8'h40);
        cyc();
        b_wd = 8'h41; exp_b.push_back(8'h41);
        cyc();
        b_re = 1'b1;
        for (int j = 2; j < 13; j++) begin
            b_wd = 8'(8'h40 + j); exp_b.push_back(8'(8'h40 + j));
            cyc();
            chk("wrap_cnt", 32'(b_cnt), 2);
        end
        b_we = 1'b0;
        repeat (2) cyc();
        b_re = 1'b0;
        chk("wrap_empty", 32'(b_empty), 1);
        chk("wrap_ov", 32'(b_ov), 0);
        chk("wrap_un", 32'(b_un), 0);
        for (int j = 0; j < 5; j++) begin
            b_we = 1'b1; b_wd = 8'(8'h50 + j); exp_b.push_back(8'(8'h50 + j));
            cyc();
        end
        b_wd = 8'h55;
        cyc();
        b_we = 1'b0;
        chk("b_full", 32'(b_full), 1);
        chk("b_cnt5", 32'(b_cnt), 5);
        chk("b_ov", 32'(b_ov), 1);
        b_re = 1'b1;
        repeat (5) cyc();
        b_re = 1'b0;
        chk("b_drain_empty", 32'(b_empty), 1);

        // Registered read port.
        c_we = 1'b1; c_wd = 8'hA5;
        cyc();
        c_we = 1'b0;
        chk("reg_rv_idle", 32'(c_rv), 0);
        chk("reg_cnt1", 32'(c_cnt), 1);
        c_re = 1'b1; exp_c.push_back(8'hA5);
        cyc();
        c_re = 1'b0;
        chk("reg_rv", 32'(c_rv), 1);
        chk("reg_rd", 32'(c_rd), 32'hA5);
        cyc();
        chk("reg_rv_drop", 32'(c_rv), 0);
        chk("reg_rd_hold", 32'(c_rd), 32'hA5);
        c_re = 1'b1;
        cyc();
        c_re = 1'b0;
        chk("reg_un", 32'(c_un), 1);
        chk("reg_un_rv", 32'(c_rv), 0);
        for (int j = 0; j < 4; j++) begin
            c_we = 1'b1; c_wd = 8'(8'hB0 + j);
            cyc();
        end
        c_we = 1'b0;
        chk("reg_cnt4", 32'(c_cnt), 4);
        c_clr = 1'b1; c_re = 1'b1;
        cyc();
        c_clr = 1'b0; c_re = 1'b0;
        chk("regclr_cnt", 32'(c_cnt), 0);
        chk("regclr_un", 32'(c_un), 0);
        chk("regclr_ov", 32'(c_ov), 0);
        chk("regclr_empty", 32'(c_empty), 1);
        chk("regclr_rv", 32'(c_rv), 0);
        c_we = 1'b1; c_wd = 8'hC7;
        cyc();
        c_we = 1'b0; c_re = 1'b1; exp_c.push_back(8'hC7);
        cyc();
        c_re = 1'b0;
        chk("regpost_rd", 32'(c_rd), 32'hC7);
        cyc();

        // Asynchronous reset with 3 words held.
        for (int j = 0; j < 3; j++) begin
            a_we = 1'b1; a_wd = 8'(8'h61 + j);
            cyc();
        end
        a_we = 1'b0;
        chk("mid_cnt3", 32'(a_cnt), 3);
        #2 reset = 1'b0;
        #1;
        chk("mid_cnt", 32'(a_cnt), 0);
        chk("mid_empty", 32'(a_empty), 1);
        chk("mid_full", 32'(a_full), 0);
        chk("mid_af", 32'(a_af), 0);
        chk("mid_ae", 32'(a_ae), 1);
        chk("mid_rv", 32'(a_rv), 0);
        chk("mid_rd", 32'(a_rd), 0);
        chk("mid_c_rv", 32'(c_rv), 0);
        chk("mid_c_rd", 32'(c_rd), 0);
        #1 reset = 1'b1;
        cyc();

        chk("a_queue_left", 32'(exp_a.size()), 0);
        chk("b_queue_left", 32'(exp_b.size()), 0);
        chk("c_queue_left", 32'(exp_c.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
